// File: rtl/hit_collision_ctrl_pkg.sv
// Shared types and constants for the collision detector and the bitmap consumers.
package collision_pkg;

    typedef enum logic [1:0] {ARMED, LATCHED, COOLDOWN} coll_state_t;

    localparam logic [3:0] EDGE_LEFT   = 4'h8;
    localparam logic [3:0] EDGE_TOP    = 4'h4;
    localparam logic [3:0] EDGE_RIGHT  = 4'h2;
    localparam logic [3:0] EDGE_BOTTOM = 4'h1;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

    // Index width for a target vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hit_collision_ctrl_if.sv
// Drawing-stream inputs and collision report outputs of hit_collision_ctrl.
interface hit_collision_ctrl_if
    import collision_pkg::*;
#(
    parameter int NUM_TARGETS = 4
);
    localparam int IDX_W = idx_width(NUM_TARGETS);

    logic                   startOfFrame;
    logic                   enable;
    logic                   drawingRequest_P;
    logic [3:0]             HitEdgeCode_P;
    logic [NUM_TARGETS-1:0] drawingRequest_T;
    logic                   collision;
    logic [3:0]             collisionEdge;
    logic [IDX_W-1:0]       collisionIndex;
    logic                   busy;
    logic [7:0]             hitCount;

    modport master (
        output startOfFrame, enable, drawingRequest_P, HitEdgeCode_P, drawingRequest_T,
        input  collision, collisionEdge, collisionIndex, busy, hitCount
    );

    modport slave (
        input  startOfFrame, enable, drawingRequest_P, HitEdgeCode_P, drawingRequest_T,
        output collision, collisionEdge, collisionIndex, busy, hitCount
    );

endinterface

// File: rtl/hit_collision_ctrl_first_hit_encoder.sv
// Combinational lowest-set-bit encoder: the lowest requesting target wins.
module first_hit_encoder
    import collision_pkg::*;
#(
    parameter  int NUM_TARGETS = 4,
    localparam int IDX_W       = idx_width(NUM_TARGETS)
) (
    input  logic [NUM_TARGETS-1:0] req,
    output logic                   any,
    output logic [IDX_W-1:0]       index
);

    always_comb begin
        any   = |req;
        index = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (req[i]) index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/hit_collision_ctrl.sv
// Frame-based player/target collision detector with per-report cooldown.
// Optional saturating report counter: define HIT_COLLISION_COUNT_EN.
module hit_collision_ctrl
    import collision_pkg::*;
#(
    parameter int NUM_TARGETS     = 4,
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic               clk,
    input  logic               resetN,
    hit_collision_ctrl_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_TARGETS);

    coll_state_t      state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [3:0]       cap_edge_q, cap_edge_d;
    logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
    logic             coll_q, coll_d;
    logic [3:0]       edge_q, edge_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q;

    logic             hit_any;
    logic [IDX_W-1:0] hit_idx;
    logic             overlap;

    first_hit_encoder #(.NUM_TARGETS(NUM_TARGETS)) u_enc (
        .req   (bus.drawingRequest_T),
        .any   (hit_any),
        .index (hit_idx)
    );

    assign overlap = bus.enable & bus.drawingRequest_P & hit_any;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_edge_d = cap_edge_q;
        cap_idx_d  = cap_idx_q;
        coll_d     = 1'b0;
        edge_d     = edge_q;
        idx_d      = idx_q;
        case (state_q)
            ARMED: begin
                if (overlap) begin
                    cap_edge_d = bus.HitEdgeCode_P;
                    cap_idx_d  = hit_idx;
                    state_d    = LATCHED;
                end
            end
            LATCHED: begin
                if (bus.startOfFrame) begin
                    coll_d = 1'b1;
                    edge_d = cap_edge_q;
                    idx_d  = cap_idx_q;
                    if (COOLDOWN_FRAMES == 0) begin
                        state_d = ARMED;
                    end else begin
                        cnt_d   = 8'(COOLDOWN_FRAMES);
                        state_d = COOLDOWN;
                    end
                end
            end
            COOLDOWN: begin
                if (bus.startOfFrame) begin
                    if (cnt_q != 8'd0)  cnt_d   = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1)  state_d = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ARMED;
            cnt_q      <= '0;
            cap_edge_q <= '0;
            cap_idx_q  <= '0;
            coll_q     <= 1'b0;
            edge_q     <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_edge_q <= cap_edge_d;
            cap_idx_q  <= cap_idx_d;
            coll_q     <= coll_d;
            edge_q     <= edge_d;
            idx_q      <= idx_d;
            // Lags the state by one cycle on both edges of busy.
            busy_q     <= (state_q != ARMED);
        end
    end

    assign bus.collision      = coll_q;
    assign bus.collisionEdge  = edge_q;
    assign bus.collisionIndex = idx_q;
    assign bus.busy           = busy_q;

`ifdef HIT_COLLISION_COUNT_EN
    logic [7:0] hit_q;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)                          hit_q <= '0;
        else if (coll_d && hit_q != 8'hFF)    hit_q <= hit_q + 8'd1;
    end
    assign bus.hitCount = hit_q;
`else
    assign bus.hitCount = 8'h00;
`endif

endmodule

// File: doc/hit_collision_ctrl.md
# hit_collision_ctrl

Frame-based collision detector on the consumer side of the bitmap drawing interface. It receives the per-pixel `drawingRequest` and `HitEdgeCode` stream from one player-object bitmap and from `NUM_TARGETS` target bitmaps. It captures the first player/target overlap in each frame and reports it as a single-cycle event after the next `startOfFrame`. A frame-count cooldown then suppresses further detection.

## Interface
Parameters:
- `NUM_TARGETS`, default 4: number of target drawing-request inputs (1..16).
- `COOLDOWN_FRAMES`, default 2: frames ignored after a report (0..255).

Ports:
- `clk`  in  1  system clock.
- `resetN`  in  1  reset; one clock, asynchronous, active-low.
- `startOfFrame`  in  1  one-cycle pulse at the frame boundary.
- `enable`  in  1  detection enable; when 0, no new capture.
- `drawingRequest_P`  in  1  player bitmap pixel is opaque.
- `HitEdgeCode_P`  in  4  player edge code {Left,Top,Right,Bottom}, aligned with `drawingRequest_P`.
- `drawingRequest_T`  in  NUM_TARGETS  per-target opaque flags, aligned with the player inputs.
- `collision`  out  1  one-cycle collision report.
- `collisionEdge`  out  4  latched player edge code of the captured hit.
- `collisionIndex`  out  $clog2(NUM_TARGETS) (min 1)  index of the hit target.
- `busy`  out  1  high in LATCHED or COOLDOWN.
- `hitCount`  out  8  saturating report count (see Configuration).

## Operation
- `overlap` = `enable & drawingRequest_P & |drawingRequest_T`, evaluated each cycle.
- Target selection: the lowest set index of `drawingRequest_T` wins.
- State machine with three states:
  - **ARMED**:
    - On `overlap`, capture `HitEdgeCode_P` and the winning index into holding registers, then go to LATCHED.
    - `startOfFrame` alone has no effect.
  - **LATCHED**:
    - Further overlaps are ignored; the captured values are kept.
    - On `startOfFrame`, arm the report.
    - If `COOLDOWN_FRAMES`==0, return to ARMED; otherwise load the cooldown counter with `COOLDOWN_FRAMES` and go to COOLDOWN.
  - **COOLDOWN**:
    - Overlaps are ignored.
    - Each `startOfFrame` decrements the counter.
    - When `startOfFrame` arrives with counter==1, return to ARMED.
- Simultaneous `startOfFrame` and `overlap`:
  - In ARMED, the overlap is captured (state goes to LATCHED) and is reported at the following `startOfFrame`.
  - In LATCHED, the report is issued and the new overlap is dropped.
- `collisionEdge` and `collisionIndex` are updated only when a report fires. They hold their value until the next report.
- `enable` deasserted in LATCHED or COOLDOWN does not cancel the pending report or the cooldown.
- Counter width is 8 bits; it never underflows.

## Timing
- Reset values:
  - state = ARMED; cooldown counter = 0.
  - `collision`=0, `collisionEdge`=4'h0, `collisionIndex`=0, `busy`=0, `hitCount`=0.
- Capture happens on the clock edge at which `overlap`=1.
- Report latency:
  - `collision` is high exactly one cycle, in the cycle after the `startOfFrame` cycle.
  - `collisionEdge` and `collisionIndex` become valid in that same cycle.
- `busy` is registered. It rises one cycle after capture and falls one cycle after the transition to ARMED.
- Reset mid-operation (asynchronous) discards any pending capture and any cooldown. No report is ever emitted for a discarded capture.

## Configuration
- `HIT_COLLISION_COUNT_EN` defined:
  - `hitCount` increments on each `collision` pulse, in the same cycle as the pulse.
  - It saturates at 8'hFF.
- Not defined: `hitCount` is tied to 8'h00 and no counter register is synthesized.

## Structure
- Shared package `collision_pkg` contains:
  - state enum `coll_state_t` {ARMED, LATCHED, COOLDOWN};
  - edge constants `EDGE_LEFT`=4'h8, `EDGE_TOP`=4'h4, `EDGE_RIGHT`=4'h2, `EDGE_BOTTOM`=4'h1;
  - `TRANSPARENT_ENCODING`=8'hFF, for bitmap consumers.
- Sub-module `first_hit_encoder`:
  - Combinational lowest-set-bit encoder, parameterized by `NUM_TARGETS`.
  - Outputs `any` and `index`.

## Test plan
- Single overlap: `drawingRequest_T`=4'b0100 with `HitEdgeCode_P`=4'h4 in frame N.
  - Expected: `collision`=1 for one cycle after the next `startOfFrame`, `collisionEdge`=4'h4, `collisionIndex`=2.
- Priority and first-capture: overlap with `drawingRequest_T`=4'b1010 and edge 4'h8, then overlap with `drawingRequest_T`=4'b0001 and edge 4'h1 in the same frame.
  - Expected: report shows index 1, edge 4'h8.
- Cooldown, `COOLDOWN_FRAMES`=2: overlaps in every frame.
  - Expected: reports after frames 0, 3 and 6 only; `busy` is high in between.
- `startOfFrame` coincident with overlap while ARMED.
  - Expected: no pulse at that boundary; pulse one cycle after the following `startOfFrame`.
- `resetN` pulled low while LATCHED.
  - Expected: all outputs 0, state ARMED, no pulse at the next `startOfFrame`.
- `HIT_COLLISION_COUNT_EN` defined, 260 reports with `COOLDOWN_FRAMES`=0.
  - Expected: `hitCount` saturates at 8'hFF.
  - Without the macro, `hitCount` stays 0.
